// File: rtl/qsys_ocram_pkg.sv
// qsys_ocram_pkg: shared types and helpers for the Avalon-MM on-chip RAM.
package qsys_ocram_pkg;
    typedef enum logic {CLEAR, READY} state_t;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;
    function automatic logic par8(input logic [7:0] b);
        return ^b;
    endfunction
    function automatic bit rd_lat_ok(input int lat);
        return lat >= RD_LAT_MIN && lat <= RD_LAT_MAX;
    endfunction
endpackage

// File: rtl/qsys_system_ocram_if.sv
// qsys_system_ocram_if: Avalon-MM slave bus bundle for the on-chip RAM.
interface qsys_system_ocram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    modport master(
        output address, byteenable, chipselect, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );
    modport slave(
        input  address, byteenable, chipselect, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/qsys_ocram_bank.sv
// qsys_ocram_bank: synchronous-read storage array with per-lane write enables.
module qsys_ocram_bank #(
    parameter int NB     = 4,
    parameter int LW     = 8,
    parameter int DEPTH  = 5120,
    parameter int ADDR_W = 13
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   we,
    input  logic                   re,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [NB-1:0]          be,
    input  logic [NB-1:0][LW-1:0]  wdata,
    output logic [NB-1:0][LW-1:0]  q
);
    logic [NB-1:0][LW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[addr][i] <= wdata[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else if (re) q <= mem[addr];
    end
endmodule

// File: rtl/qsys_system_ocram.sv
// qsys_system_ocram: Avalon-MM on-chip RAM with zero-fill, pipelined reads and OOB detection.
// Defining OCRAM_PARITY_EN adds one even-parity bit per byte and drives par_err.
module qsys_system_ocram
    import qsys_ocram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 5120,
    parameter int ADDR_W         = 13,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    qsys_system_ocram_if.slave  bus,
    input  logic                clken,
    input  logic                reset_req,
    output logic                init_done,
    output logic                err_oob,
    output logic                par_err
);
    localparam int NB = DATA_W / 8;
`ifdef OCRAM_PARITY_EN
    localparam int LW = 9;
`else
    localparam int LW = 8;
`endif
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    if (!rd_lat_ok(RD_LATENCY) || DATA_W % 8 != 0) begin : g_bad_cfg
        $error("qsys_system_ocram: illegal RD_LATENCY or DATA_W");
    end

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     clr_cnt, clr_nxt, bank_addr;
    logic                  en, acc, rd_acc, in_range, clr_we, bank_we;
    logic [NB-1:0]         bank_be, bad;
    logic [NB-1:0][LW-1:0] bank_wdata, bank_q;
    logic                  v1, oob1, p1, v2, p2;
    logic [DATA_W-1:0]     d1, d2;

    always_comb begin
        en         = clken & ~reset_req;
        in_range   = {1'b0, bus.address} < DEPTH_V;
        acc        = (state == READY) & en & bus.chipselect & (bus.read | bus.write);
        rd_acc     = acc & bus.read & ~bus.write;
        clr_we     = (state == CLEAR) & en & (CLEAR_ON_RESET != 0);
        bank_we    = clr_we | (acc & bus.write & in_range);
        bank_addr  = clr_we ? clr_cnt : bus.address;
        bank_be    = clr_we ? '1 : bus.byteenable;
        bank_wdata = '0;
        d1         = '0;
        bad        = '0;
        for (int i = 0; i < NB; i++) begin
`ifdef OCRAM_PARITY_EN
            bank_wdata[i] = clr_we ? '0 : {par8(bus.writedata[8*i +: 8]), bus.writedata[8*i +: 8]};
            bad[i]        = ^bank_q[i];
`else
            bank_wdata[i] = clr_we ? '0 : bus.writedata[8*i +: 8];
`endif
            d1[8*i +: 8] = oob1 ? 8'h00 : bank_q[i][7:0];
        end
        p1        = ~oob1 & (|bad);
        state_nxt = state;
        clr_nxt   = clr_cnt;
        if (state == CLEAR) begin
            if (CLEAR_ON_RESET == 0) state_nxt = READY;
            else if (en) begin
                clr_nxt   = (clr_cnt == ADDR_W'(DEPTH - 1)) ? '0 : clr_cnt + 1'b1;
                state_nxt = (clr_cnt == ADDR_W'(DEPTH - 1)) ? READY : CLEAR;
            end
        end
        init_done         = state == READY;
        bus.waitrequest   = ~((state == READY) & en);
        bus.readdata      = (RD_LATENCY == 2) ? d2 : d1;
        bus.readdatavalid = en & ((RD_LATENCY == 2) ? v2 : v1);
        par_err           = bus.readdatavalid & ((RD_LATENCY == 2) ? p2 : p1);
    end

    // Pipeline stages advance only on enabled cycles; the output is masked while frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            v1      <= 1'b0;
            oob1    <= 1'b0;
            v2      <= 1'b0;
            d2      <= '0;
            p2      <= 1'b0;
            err_oob <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_nxt;
            err_oob <= acc & ~in_range & ~(bus.read & bus.write);
            if (en) begin
                v1 <= rd_acc;
                v2 <= v1;
                if (rd_acc) oob1 <= ~in_range;
                if (v1) begin
                    d2 <= d1;
                    p2 <= p1;
                end
            end
        end
    end

    qsys_ocram_bank #(.NB(NB), .LW(LW), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (bank_we),
        .re      (rd_acc & in_range),
        .addr    (bank_addr),
        .be      (bank_be),
        .wdata   (bank_wdata),
        .q       (bank_q)
    );
endmodule

// File: tb/tb_qsys_system_ocram.sv
// tb_qsys_system_ocram: scoreboard bench with a word-array reference model for qsys_system_ocram.
module tb_qsys_system_ocram;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 5;
    localparam int LAT    = 2;

    typedef struct {
        logic [31:0] data;
        bit          par;
        int          acc_cyc;
        bit          chk;
    } exp_t;

    logic clk = 0, reset_n = 0, clken = 1, reset_req = 0;
    logic init_done, err_oob, par_err;

    qsys_system_ocram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    qsys_system_ocram #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .RD_LATENCY(LAT), .CLEAR_ON_RESET(1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .clken     (clken),
        .reset_req (reset_req),
        .init_done (init_done),
        .err_oob   (err_oob),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0, errors = 0;
    bit          ready_m = 0, chk_lat = 1;
    logic [31:0] mem_m [DEPTH];
    bit          bad_m [DEPTH];
    bit          err_sched [int];
    exp_t        sb [$];
    exp_t        e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one bus cycle; the model applies the access if it will be accepted at the next edge.
    task automatic step(input bit cs, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d, input logic [3:0] be, input bit ck, input bit rq);
        bit oob;
        @(posedge clk);
        #1;
        bus.chipselect = cs; bus.read = rd; bus.write = wr; bus.address = a;
        bus.writedata = d; bus.byteenable = be; clken = ck; reset_req = rq;
        oob = int'(a) >= DEPTH;
        if (ready_m && ck && !rq && cs && (rd || wr)) begin
            if (wr && !oob)
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
            if (rd && !wr)
                sb.push_back('{oob ? 32'h0 : mem_m[a], oob ? 1'b0 : bad_m[a], cyc + 1, chk_lat});
            if (oob && !(rd && wr)) err_sched[cyc + 1] = 1;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, '0, '0, '0, 1, 0);
    endtask

    task automatic rd(input int a);
        step(1, 1, 0, ADDR_W'(a), $urandom, 4'hf, 1, 0);
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        step(1, 0, 1, ADDR_W'(a), d, be, 1, 0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() > 0; i++) idle();
        chk(name, sb.size(), 0);
    endtask

    task automatic do_reset();
        reset_n = 0;
        ready_m = 0;
        sb.delete();
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            bad_m[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        repeat (DEPTH) idle();
        ready_m = 1;
    endtask

    always @(negedge clk) begin
        chk("init_done", init_done, ready_m);
        chk("waitrequest", bus.waitrequest, !(ready_m && clken && !reset_req));
        chk("err_oob", err_oob, err_sched.exists(cyc));
        if (!(clken && !reset_req)) chk("rdv_frozen", bus.readdatavalid, 0);
        if (bus.readdatavalid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdv_spurious: readdatavalid=1 with no read outstanding (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("readdata", bus.readdata, e.data);
                chk("par_err", par_err, e.par);
                if (e.chk) chk("latency", cyc - e.acc_cyc, LAT - 1);
            end
        end else chk("par_err_idle", par_err, 0);
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bus.chipselect = 0; bus.read = 0; bus.write = 0; bus.address = '0;
        bus.writedata = '0; bus.byteenable = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            bad_m[i] = 0;
        end
        #23;
        chk("rst_readdata", bus.readdata, 0);
        chk("rst_rdv", bus.readdatavalid, 0);
        @(negedge clk);
        reset_n = 1;
        repeat (DEPTH) idle();
        ready_m = 1;
        rd(5);
        wr(3, 32'h11223344, 4'hf);
        wr(3, 32'hDEADBEEF, 4'b0101);
        rd(3);
        for (int a = 0; a < 4; a++) rd(a);
        wr(16, 32'hA5A5A5A5, 4'hf);
        rd(16);
        rd(0);
        for (int a = 4; a < 12; a++) wr(a, $urandom, 4'hf);
        chk_lat = 0;
        for (int i = 0; i < 8; i++) step(1, 1, 0, ADDR_W'(4 + i), '0, 4'hf, 1, i >= 3 && i < 6);
        drain("drain_freeze");
        repeat (400)
            step($urandom % 10 != 0, 1'($urandom), 1'($urandom), ADDR_W'($urandom_range(0, 19)),
                 $urandom, 4'($urandom), $urandom % 10 != 0, $urandom % 20 == 0);
        drain("drain_random");
        chk_lat = 1;
        rd(1);
        rd(2);
        @(posedge clk);
        #1;
        bus.chipselect = 0; bus.read = 0;
        do_reset();
        rd(3);
        rd(7);
        rd(16);
        drain("drain_after_reset");
`ifdef OCRAM_PARITY_EN
        wr(2, 32'h12345678, 4'hf);
        wr(1, 32'h9ABCDEF0, 4'hf);
        idle();
        dut.u_bank.mem[2][0][0] = ~dut.u_bank.mem[2][0][0];
        mem_m[2][0] = ~mem_m[2][0];
        bad_m[2] = 1;
        rd(2);
        rd(1);
        drain("drain_parity");
`endif
        repeat (3) idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
